// File: rtl/cp0_nested_exc_if.sv
// Commit-stage exception, eret and mfc0/mtc0 bundle between the pipeline (master) and CP0 (slave).
// No handshake: every signal is valid each cycle; exc_req/exc_code/cp_rd are combinational from CP0.
interface cp0_nested_exc_if #(
    parameter int NUM_HW_INT = 6
);
    logic [NUM_HW_INT-1:0] hw_int;
    logic                  exc_sys;
    logic                  exc_ri;
    logic                  exc_ov;
    logic [31:0]           exc_epc;
    logic                  eret;
    logic                  cp_we;
    logic [4:0]            cp_wa;
    logic [31:0]           cp_wd;
    logic [4:0]            cp_ra;
    logic [31:0]           cp_rd;
    logic                  exc_req;
    logic [4:0]            exc_code;
    logic [31:0]           epc_out;
    logic [31:0]           status_out;
    logic [31:0]           cause_out;
    logic [2:0]            level_out;

    modport master (
        output hw_int, exc_sys, exc_ri, exc_ov, exc_epc, eret,
        output cp_we, cp_wa, cp_wd, cp_ra,
        input  cp_rd, exc_req, exc_code, epc_out, status_out, cause_out, level_out
    );

    modport slave (
        input  hw_int, exc_sys, exc_ri, exc_ov, exc_epc, eret,
        input  cp_we, cp_wa, cp_wd, cp_ra,
        output cp_rd, exc_req, exc_code, epc_out, status_out, cause_out, level_out
    );
endinterface

// File: rtl/cp0_nested_exc.sv
// Nesting CP0 (Status/Cause/EPC stack); take/eret/mtc0 act at the next edge, mfc0 and exc_req are same-cycle.
// No backpressure: a take always wins and drops a same-cycle mtc0. Optional Count/Compare timer: CP0_TIMER_EN.
module cp0_nested_exc #(
    parameter int NUM_HW_INT = 6,
    parameter int NEST_DEPTH = 3
) (
    input logic             clk,
    input logic             rst,
    cp0_nested_exc_if.slave bus
);
    localparam int         IW       = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [2:0] MAX_LVL  = 3'(NEST_DEPTH);
    localparam logic [4:0] CODE_INT = 5'd0;
    localparam logic [4:0] CODE_SYS = 5'd8;
    localparam logic [4:0] CODE_RI  = 5'd10;
    localparam logic [4:0] CODE_OV  = 5'd12;
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
`ifdef CP0_TIMER_EN
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
`endif

    logic                  ie_q, ie_d;
    logic [NEST_DEPTH-1:0] hist_q, hist_d;
    logic [7:0]            im_q, im_d;
    logic                  ovf_q, ovf_d;
    logic [4:0]            code_q, code_d;
    logic [1:0]            swip_q, swip_d;
    logic [NUM_HW_INT-1:0] ip_q;
    logic [2:0]            level_q, level_d;
    logic [31:0]           epc_q [NEST_DEPTH];
    logic [31:0]           epc_d [NEST_DEPTH];

    logic [5:0]    hw_ip;
    logic [7:0]    ip_all;
    logic          not_full;
    logic          int_pend;
    logic          take;
    logic          mtc0;
    logic [4:0]    req_code;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] push_idx;
    logic [31:0]   status;
    logic [31:0]   cause;
    logic [31:0]   rd;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tpend_q, tpend_d;
    logic        started_q;
`endif

    always_comb begin
        hw_ip = '0;
        hw_ip[NUM_HW_INT-1:0] = ip_q;
`ifdef CP0_TIMER_EN
        hw_ip[5] = tpend_q;
`endif
    end

    assign ip_all   = {hw_ip, swip_q};
    assign not_full = (level_q < MAX_LVL);
    assign int_pend = ie_q && not_full && |(ip_all & im_q);
    assign take     = bus.exc_ov | bus.exc_ri | bus.exc_sys | int_pend;
    assign mtc0     = bus.cp_we & ~take;

    always_comb begin
        req_code = CODE_INT;
        if (bus.exc_ov)       req_code = CODE_OV;
        else if (bus.exc_ri)  req_code = CODE_RI;
        else if (bus.exc_sys) req_code = CODE_SYS;
    end

    // At full depth only a synchronous exception can take; it reuses the top slot.
    assign top_idx  = (level_q == 3'd0) ? '0 : IW'(level_q - 3'd1);
    assign push_idx = not_full ? IW'(level_q) : IW'(NEST_DEPTH - 1);

    always_comb begin
        ie_d    = ie_q;
        hist_d  = hist_q;
        im_d    = im_q;
        ovf_d   = ovf_q;
        code_d  = code_q;
        swip_d  = swip_q;
        level_d = level_q;
        epc_d   = epc_q;
        if (take) begin
            epc_d[push_idx] = bus.exc_epc;
            if (not_full) level_d = level_q + 3'd1;
            else          ovf_d   = 1'b1;
            hist_d = NEST_DEPTH'({hist_q, ie_q});
            ie_d   = 1'b0;
            code_d = req_code;
        end else begin
            if (bus.eret && level_q != 3'd0) begin
                ie_d    = hist_q[0];
                hist_d  = hist_q >> 1;
                level_d = level_q - 3'd1;
            end
            // Applied after eret so a Status write overrides the restored IE.
            if (mtc0) begin
                case (bus.cp_wa)
                    REG_STATUS: begin
                        ie_d = bus.cp_wd[0];
                        im_d = bus.cp_wd[15:8];
                        if (bus.cp_wd[31]) ovf_d = 1'b0;
                    end
                    REG_CAUSE: swip_d         = bus.cp_wd[9:8];
                    REG_EPC:   epc_d[top_idx] = bus.cp_wd;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q    <= 1'b0;
            hist_q  <= '0;
            im_q    <= '0;
            ovf_q   <= 1'b0;
            code_q  <= '0;
            swip_q  <= '0;
            ip_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) epc_q[i] <= '0;
        end else begin
            ie_q    <= ie_d;
            hist_q  <= hist_d;
            im_q    <= im_d;
            ovf_q   <= ovf_d;
            code_q  <= code_d;
            swip_q  <= swip_d;
            ip_q    <= bus.hw_int;
            level_q <= level_d;
            epc_q   <= epc_d;
        end
    end

`ifdef CP0_TIMER_EN
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        tpend_d   = tpend_q;
        // started_q masks the Count==Compare==0 match right after reset.
        if (started_q && count_q == compare_q) tpend_d = 1'b1;
        if (mtc0 && bus.cp_wa == REG_COUNT) count_d = bus.cp_wd;
        if (mtc0 && bus.cp_wa == REG_COMPARE) begin
            compare_d = bus.cp_wd;
            tpend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            tpend_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tpend_q   <= tpend_d;
            started_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        status = '0;
        status[0]               = ie_q;
        status[4 +: NEST_DEPTH] = hist_q;
        status[15:8]            = im_q;
        status[31]              = ovf_q;
    end

    assign cause = {16'd0, hw_ip, swip_q, 1'b0, code_q, 2'b00};

    always_comb begin
        case (bus.cp_ra)
            REG_STATUS:  rd = status;
            REG_CAUSE:   rd = cause;
            REG_EPC:     rd = epc_q[top_idx];
`ifdef CP0_TIMER_EN
            REG_COUNT:   rd = count_q;
            REG_COMPARE: rd = compare_q;
`endif
            default:     rd = '0;
        endcase
    end

    assign bus.cp_rd      = rd;
    assign bus.exc_req    = take;
    assign bus.exc_code   = req_code;
    assign bus.epc_out    = epc_q[top_idx];
    assign bus.status_out = status;
    assign bus.cause_out  = cause;
    assign bus.level_out  = level_q;
endmodule

// File: tb/tb_cp0_nested_exc.sv
// Bench for cp0_nested_exc: directed vector table, nesting/reset/timer sequences, then random traffic vs a queue-based model.
module tb_cp0_nested_exc;
    localparam int NHW = 6;
    localparam int ND  = 3;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cp0_nested_exc_if #(.NUM_HW_INT(NHW)) bus ();
    cp0_nested_exc #(.NUM_HW_INT(NHW), .NEST_DEPTH(ND)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ex;      // {ov, ri, sys, eret}
        logic [31:0] epc;
        logic [5:0]  hw;
        logic        xreq;
        logic [4:0]  xcode;
        logic [2:0]  xlvl;
        logic [31:0] xepc;
        logic [31:0] xst;
        logic [31:0] xca;
    } vec_t;

    vec_t tbl [16];

    // Reference model: EPC slots indexed by level, IE history as a queue (front = most recent).
    bit          m_ie;
    bit          m_hist[$];
    logic [7:0]  m_im;
    bit          m_ovf;
    logic [4:0]  m_ecode;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;
    logic [31:0] m_epc [ND];
    int          m_lvl;
    logic [31:0] m_cnt, m_cmp;
    bit          m_tp, m_started;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.hw_int = '0; bus.exc_sys = 0; bus.exc_ri = 0; bus.exc_ov = 0;
        bus.exc_epc = '0; bus.eret = 0; bus.cp_we = 0; bus.cp_wa = '0;
        bus.cp_wd = '0; bus.cp_ra = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
        bus.cp_we = 1'b1; bus.cp_wa = wa; bus.cp_wd = wd;
        tick();
        bus.cp_we = 1'b0;
    endtask

    task automatic m_reset();
        m_ie = 0; m_hist.delete();
        for (int k = 0; k < ND; k++) m_hist.push_back(1'b0);
        m_im = '0; m_ovf = 0; m_ecode = '0; m_sw = '0; m_hw = '0; m_lvl = 0;
        for (int k = 0; k < ND; k++) m_epc[k] = '0;
        m_cnt = '0; m_cmp = '0; m_tp = 0; m_started = 0;
    endtask

    function automatic logic [5:0] m_hwip();
        logic [5:0] h;
        h = m_hw;
`ifdef CP0_TIMER_EN
        h[5] = m_tp;
`endif
        return h;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = m_ie;
        for (int k = 0; k < ND; k++) s[4 + k] = m_hist[k];
        s[15:8] = m_im;
        s[31] = m_ovf;
        return s;
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = '0;
        c[6:2] = m_ecode;
        c[9:8] = m_sw;
        c[15:10] = m_hwip();
        return c;
    endfunction

    function automatic logic [31:0] m_epcout();
        return (m_lvl > 0) ? m_epc[m_lvl - 1] : m_epc[0];
    endfunction

    function automatic bit m_req();
        bit pend;
        pend = m_ie && (m_lvl < ND) && (({m_hwip(), m_sw} & m_im) != 8'd0);
        return bus.exc_ov || bus.exc_ri || bus.exc_sys || pend;
    endfunction

    function automatic logic [4:0] m_reqcode();
        if (bus.exc_ov)  return 5'd12;
        if (bus.exc_ri)  return 5'd10;
        if (bus.exc_sys) return 5'd8;
        return 5'd0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] ra);
        case (ra)
            5'd12: return m_status();
            5'd13: return m_cause();
            5'd14: return m_epcout();
`ifdef CP0_TIMER_EN
            5'd9:  return m_cnt;
            5'd11: return m_cmp;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step();
        bit          take, wr, tp_n;
        int          top;
        logic [4:0]  code;
        logic [31:0] cnt_n;
        take = m_req();
        code = m_reqcode();
        top  = (m_lvl > 0) ? m_lvl - 1 : 0;
        wr   = bus.cp_we && !take;
        tp_n = m_tp;
        if (m_started && m_cnt == m_cmp) tp_n = 1;
        cnt_n = m_cnt + 32'd1;
`ifdef CP0_TIMER_EN
        if (wr && bus.cp_wa == 5'd9) cnt_n = bus.cp_wd;
        if (wr && bus.cp_wa == 5'd11) begin m_cmp = bus.cp_wd; tp_n = 0; end
`endif
        m_cnt = cnt_n; m_tp = tp_n; m_started = 1;
        if (take) begin
            if (m_lvl < ND) begin m_epc[m_lvl] = bus.exc_epc; m_lvl++; end
            else begin m_epc[ND - 1] = bus.exc_epc; m_ovf = 1; end
            m_hist.push_front(m_ie);
            void'(m_hist.pop_back());
            m_ie = 0;
            m_ecode = code;
        end else begin
            if (bus.eret && m_lvl > 0) begin
                m_ie = m_hist.pop_front();
                m_hist.push_back(1'b0);
                m_lvl--;
            end
            if (wr) begin
                case (bus.cp_wa)
                    5'd12: begin m_ie = bus.cp_wd[0]; m_im = bus.cp_wd[15:8]; if (bus.cp_wd[31]) m_ovf = 0; end
                    5'd13: m_sw = bus.cp_wd[9:8];
                    5'd14: m_epc[top] = bus.cp_wd;
                    default: ;
                endcase
            end
        end
        m_hw = bus.hw_int;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        //         we  wa     wd            ex       epc          hw    req code lvl  epc_out       status        cause
        tbl[0]  = '{0, 5'd0,  32'h0,        4'b0000, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h0,      32'h0,       32'h0};
        tbl[1]  = '{1, 5'd12, 32'h401,      4'b0000, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h0,      32'h401,     32'h0};
        tbl[2]  = '{0, 5'd0,  32'h0,        4'b0000, 32'h0,       6'h1, 0, 5'd0,  3'd0, 32'h0,      32'h401,     32'h400};
        tbl[3]  = '{0, 5'd0,  32'h0,        4'b0000, 32'h1000,    6'h1, 1, 5'd0,  3'd1, 32'h1000,   32'h410,     32'h400};
        tbl[4]  = '{0, 5'd0,  32'h0,        4'b0001, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h1000,   32'h401,     32'h0};
        tbl[5]  = '{0, 5'd0,  32'h0,        4'b1010, 32'h100,     6'h0, 1, 5'd12, 3'd1, 32'h100,    32'h410,     32'h30};
        tbl[6]  = '{1, 5'd14, 32'hDEAD,     4'b0100, 32'h200,     6'h0, 1, 5'd10, 3'd2, 32'h200,    32'h420,     32'h28};
        tbl[7]  = '{0, 5'd0,  32'h0,        4'b0001, 32'h0,       6'h0, 0, 5'd0,  3'd1, 32'h100,    32'h410,     32'h28};
        tbl[8]  = '{0, 5'd0,  32'h0,        4'b0001, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h100,    32'h401,     32'h28};
        tbl[9]  = '{0, 5'd0,  32'h0,        4'b0001, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h100,    32'h401,     32'h28};
        tbl[10] = '{1, 5'd13, 32'hFFFFFFFF, 4'b0000, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h100,    32'h401,     32'h328};
        tbl[11] = '{1, 5'd12, 32'h300,      4'b0000, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h100,    32'h300,     32'h328};
        tbl[12] = '{1, 5'd12, 32'h301,      4'b0000, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h100,    32'h301,     32'h328};
        tbl[13] = '{0, 5'd0,  32'h0,        4'b0000, 32'h500,     6'h0, 1, 5'd0,  3'd1, 32'h500,    32'h310,     32'h300};
        tbl[14] = '{1, 5'd13, 32'h0,        4'b0000, 32'h0,       6'h0, 0, 5'd0,  3'd1, 32'h500,    32'h310,     32'h0};
        tbl[15] = '{1, 5'd12, 32'h0,        4'b0001, 32'h0,       6'h0, 0, 5'd0,  3'd0, 32'h500,    32'h0,       32'h0};

        for (int i = 0; i < 16; i++) begin
            bus.cp_we = tbl[i].we; bus.cp_wa = tbl[i].wa; bus.cp_wd = tbl[i].wd;
            {bus.exc_ov, bus.exc_ri, bus.exc_sys, bus.eret} = tbl[i].ex;
            bus.exc_epc = tbl[i].epc; bus.hw_int = tbl[i].hw;
            #1;
            check($sformatf("vec%0d_req", i), 32'(bus.exc_req), 32'(tbl[i].xreq));
            if (tbl[i].xreq) check($sformatf("vec%0d_code", i), 32'(bus.exc_code), 32'(tbl[i].xcode));
            tick();
            check($sformatf("vec%0d_lvl", i), 32'(bus.level_out), 32'(tbl[i].xlvl));
            check($sformatf("vec%0d_epc", i), bus.epc_out, tbl[i].xepc);
            check($sformatf("vec%0d_status", i), bus.status_out, tbl[i].xst);
            check($sformatf("vec%0d_cause", i), bus.cause_out, tbl[i].xca);
        end
        idle();

        // Nest past the limit, then unwind.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.exc_sys = 1'b1;
            bus.exc_epc = 32'(16 * (k + 1));
            tick();
            check($sformatf("nest%0d_lvl", k), 32'(bus.level_out), (k < 3) ? 32'(k + 1) : 32'd3);
            check($sformatf("nest%0d_epc", k), bus.epc_out, 32'(16 * (k + 1)));
        end
        idle();
        check("nest_ovf", 32'(bus.status_out[31]), 32'd1);
        mtc0(5'd12, 32'h0);
        check("ovf_keep", 32'(bus.status_out[31]), 32'd1);
        bus.eret = 1'b1;
        tick();
        check("eret1_epc", bus.epc_out, 32'h20);
        tick();
        check("eret2_epc", bus.epc_out, 32'h10);
        tick();
        check("eret3_lvl", 32'(bus.level_out), 32'd0);
        bus.eret = 1'b0;
        mtc0(5'd12, 32'h8000_0000);
        check("ovf_w1c", 32'(bus.status_out[31]), 32'd0);

        // Asynchronous reset while inside a handler.
        bus.exc_sys = 1'b1; bus.exc_epc = 32'h77;
        tick();
        idle();
        check("hnd_lvl", 32'(bus.level_out), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_lvl", 32'(bus.level_out), 32'd0);
        check("arst_epc", bus.epc_out, 32'h0);
        check("arst_status", bus.status_out, 32'h0);
        check("arst_cause", bus.cause_out, 32'h0);
        rst = 1'b0;

`ifdef CP0_TIMER_EN
        do_reset();
        tick();
        tick();
        check("tmr_first", 32'(bus.cause_out[15]), 32'd0);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("tmr_wait%0d", k), 32'(bus.cause_out[15]), 32'd0);
        end
        tick();
        check("tmr_hit", 32'(bus.cause_out[15]), 32'd1);
        mtc0(5'd11, 32'h100);
        check("tmr_clear", 32'(bus.cause_out[15]), 32'd0);
`endif

        // Random traffic against the model.
        do_reset();
        m_reset();
        for (int c = 0; c < 400; c++) begin
            bus.hw_int  = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
            bus.exc_ov  = ($urandom_range(0, 11) == 0);
            bus.exc_ri  = ($urandom_range(0, 11) == 0);
            bus.exc_sys = ($urandom_range(0, 9) == 0);
            bus.eret    = ($urandom_range(0, 3) == 0);
            bus.exc_epc = $urandom;
            bus.cp_we   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: bus.cp_wa = 5'd12;
                1: bus.cp_wa = 5'd13;
                2: bus.cp_wa = 5'd14;
                3: bus.cp_wa = 5'd9;
                4: bus.cp_wa = 5'd11;
                default: bus.cp_wa = 5'($urandom_range(0, 31));
            endcase
            bus.cp_wd = $urandom;
            case ($urandom_range(0, 6))
                0: bus.cp_ra = 5'd12;
                1: bus.cp_ra = 5'd13;
                2: bus.cp_ra = 5'd14;
                3: bus.cp_ra = 5'd9;
                4: bus.cp_ra = 5'd11;
                default: bus.cp_ra = 5'($urandom_range(0, 31));
            endcase
            #1;
            check("rnd_req", 32'(bus.exc_req), 32'(m_req()));
            if (m_req()) check("rnd_code", 32'(bus.exc_code), 32'(m_reqcode()));
            check("rnd_rd", bus.cp_rd, m_rd(bus.cp_ra));
            m_step();
            tick();
            check("rnd_lvl", 32'(bus.level_out), 32'(m_lvl));
            check("rnd_epc", bus.epc_out, m_epcout());
            check("rnd_status", bus.status_out, m_status());
            check("rnd_cause", bus.cause_out, m_cause());
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0_nested_exc.md
Name: cp0_nested_exc

Overview:
Parametrised coprocessor-0 for the pipelined MIPS core. It holds Status, Cause and a stack of EPC registers, so exceptions can nest up to NEST_DEPTH levels. It prioritises hardware interrupts, software interrupts and synchronous exceptions (syscall, reserved instruction, overflow). It tells the NPC/pipeline when to redirect, and serves mfc0/mtc0/eret.

Parameters:
NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[15:10] and Status.IM[15:10].
NEST_DEPTH, 3, maximum nesting level (1..4); depth of the EPC stack and the IE-history stack.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, asynchronous, active-high.
hw_int  in  NUM_HW_INT  level-sensitive interrupt requests.
exc_sys  in  1  syscall in commit stage.
exc_ri  in  1  reserved/unimplemented instruction in commit stage.
exc_ov  in  1  arithmetic overflow in commit stage.
exc_epc  in  32  PC to save on exception.
eret  in  1  eret in commit stage.
cp_we  in  1  mtc0 write enable.
cp_wa  in  5  mtc0 register number.
cp_wd  in  32  mtc0 data.
cp_ra  in  5  mfc0 register number.
cp_rd  out  32  mfc0 data, combinational.
exc_req  out  1  combinational; an exception/interrupt is taken at the next edge.
exc_code  out  5  combinational ExcCode of the pending request.
epc_out  out  32  top-of-stack EPC, for eret.
status_out  out  32  Status register.
cause_out  out  32  Cause register.
level_out  out  3  current nesting level (0..NEST_DEPTH).

Behaviour:
- Reset: Status=0, Cause=0, all EPC entries=0, IE history=0, level=0, ip_q=0, overflow flag=0. All outputs derive from these; exc_req=0.
- Status layout:
  - [0] IE.
  - [7:4] IE history; bit 4 is the most recent; bits above NEST_DEPTH read 0.
  - [15:8] IM.
  - [31] OVF sticky nest-overflow flag, read-only, cleared by a write with bit31=1 (write-1-to-clear).
  - Other bits read 0.
- Cause layout:
  - [6:2] ExcCode.
  - [9:8] software IP, read/write.
  - [15:10] hardware IP, read-only, driven from ip_q.
  - Other bits read 0.
- ip_q <= hw_int every cycle, so there is 1 cycle of sampling latency.
- int_pend = IE && level<NEST_DEPTH && |(Cause.IP[15:8] & Status.IM[15:8]).
- Priority, highest first: exc_ov (code 12), exc_ri (10), exc_sys (8), int_pend (0). exc_req = OR of the four; exc_code is the winner's code.
- Take (exc_req=1 at edge):
  - If level<NEST_DEPTH: epc[level] <= exc_epc; level++.
  - If level==NEST_DEPTH (synchronous exception only): overwrite epc[NEST_DEPTH-1], level unchanged, OVF<=1.
  - In both cases: IE history <= {history, IE} shifted left by one into [4]; IE<=0; Cause.ExcCode<=exc_code.
- eret (and no take in the same cycle):
  - If level>0: IE<=history[4]; history shifts right by one; level--.
  - If level==0: no state change.
- epc_out = epc[level-1] when level>0, else epc[0].
- mtc0 executes only when cp_we=1 and no take occurs that cycle; a take drops the write.
  - Reg 12 writes IE and IM.
  - Reg 13 writes Cause[9:8] only.
  - Reg 14 writes the EPC entry currently shown on epc_out.
  - Any other address: write ignored.
- Same-cycle eret and mtc0 (no take): both apply. A Status write overrides the IE restored by eret.
- mfc0: reg 12/13/14 return Status/Cause/epc_out. Other addresses return 0, except 9/11 when the timer is enabled.
- Asserting rst mid-handler returns every register to its reset value immediately.

Optional Feature:
Macro CP0_TIMER_EN.
- Defined:
  - Adds a 32-bit Count (reg 9, +1 every clk, writable) and Compare (reg 11, writable).
  - At the edge where Count==Compare, timer pending is set; it drives Cause.IP[15], replacing hw_int[5].
  - A write to Compare clears timer pending.
  - Reset sets Count=0, Compare=0 and timer pending=0.
  - Timer pending is not set during the first cycle out of reset.
- Undefined: no timer logic; regs 9/11 read 0, writes are ignored, and IP[15] comes from hw_int[5].

Test Plan:
- Set Status=0x0000_0401 (IE, IM10); hw_int[0]=1 → exc_req rises 1 cycle later with exc_code=0. At the take: epc_out=exc_epc, level=1, IE=0, Status[4]=1.
- exc_ov=1 and exc_sys=1 in the same cycle with exc_epc=0x100 → exc_code=12, Cause[6:2]=12, epc_out=0x100.
- Nest 3 syscalls with EPCs 0x10, 0x20, 0x30, then a 4th with EPC 0x40 → level stays 3, epc_out=0x40, Status[31]=1. Then 3 erets → epc_out reads 0x20, then 0x10, then level=0.
- cp_we to reg 14 with 0xDEAD in the same cycle as exc_ri → write dropped, epc_out=exc_epc, exc_code=10.
- eret at level 0 → no register change. mtc0 reg 13 with 0xFFFF_FFFF → Cause reads only [9:8]=3 plus the hardware IP bits.
- CP0_TIMER_EN: write Compare=5, Count=0 → Cause[15] sets after 5 cycles. Writing Compare clears Cause[15].
